// File: rtl/prime_candidate_gen_pkg.sv
// Shared types and helpers for the RSA prime-candidate path.
// Optional macro used by the candidate generator: PRIME_CAND_MOD3_FILTER_EN.
package rsa_rng_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} cand_state_t;

    // OR-masks applied to the lowest and highest captured words.
    localparam logic       LO_FORCE = 1'b1;   // bit 0 of word 0 (odd)
    localparam logic [1:0] HI_FORCE = 2'b11;  // top two bits of word NW-1

    // Number of random words per candidate.
    function automatic int unsigned num_words(input int unsigned key_width,
                                              input int unsigned word_width);
        return key_width / word_width;
    endfunction

    // (a + b) mod 3 for a in 0..2 and b in 0..3.
    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/prime_candidate_gen_if.sv
// Candidate valid/ready hand-off from the generator to the primality tester.
interface prime_candidate_gen_if #(
    parameter int unsigned KEY_WIDTH = 512
);
    logic                 cand_valid;
    logic                 cand_ready;
    logic [KEY_WIDTH-1:0] cand_out;

    modport master (output cand_valid, output cand_out, input  cand_ready);
    modport slave  (input  cand_valid, input  cand_out, output cand_ready);
endinterface

// File: rtl/prime_candidate_gen_word_mod3.sv
// Combinational residue of one word modulo 3. Since 4 == 1 (mod 3), the
// residue is the mod-3 sum of the word's 2-bit digits.
module word_mod3
    import rsa_rng_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic [WORD_WIDTH-1:0] word,
    output logic [1:0]            residue
);

    // Fold 2-bit digits into a running mod-3 sum.
    always_comb begin
        residue = '0;
        for (int unsigned i = 0; i < WORD_WIDTH / 2; i++) begin
            residue = mod3_add(residue, word[2*i +: 2]);
        end
    end

endmodule

// File: rtl/prime_candidate_gen.sv
// Assembles KEY_WIDTH/WORD_WIDTH random words into one odd, full-width prime
// candidate and presents it over a valid/ready handshake.
// Optional macro: PRIME_CAND_MOD3_FILTER_EN discards candidates divisible by 3
// and exposes a saturating reject counter.
module prime_candidate_gen
    import rsa_rng_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned KEY_WIDTH  = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] rand_in,
    input  logic                  start,
    output logic                  busy,
    prime_candidate_gen_if.master cand
`ifdef PRIME_CAND_MOD3_FILTER_EN
    ,
    output logic [15:0]           reject_cnt
`endif
);

    localparam int unsigned NW = num_words(KEY_WIDTH, WORD_WIDTH);
    localparam int unsigned CW = $clog2(NW);
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    localparam logic [WORD_WIDTH-1:0] LO_MASK = {{(WORD_WIDTH-1){1'b0}}, LO_FORCE};
    localparam logic [WORD_WIDTH-1:0] HI_MASK = {HI_FORCE, {(WORD_WIDTH-2){1'b0}}};

    cand_state_t           state;
    logic [CW-1:0]         cnt;
    logic [WORD_WIDTH-1:0] forced_word;

    // Apply the odd / top-two-bit forcing to the lane being captured.
    always_comb begin
        forced_word = rand_in;
        if (cnt == '0)  forced_word = forced_word | LO_MASK;
        if (cnt == LAST) forced_word = forced_word | HI_MASK;
    end

`ifdef PRIME_CAND_MOD3_FILTER_EN
    logic [1:0]  word_res;
    logic [1:0]  res_q;
    logic [1:0]  res_sum;
    logic [15:0] reject_q;

    word_mod3 #(.WORD_WIDTH(WORD_WIDTH)) u_word_mod3 (
        .word    (forced_word),
        .residue (word_res)
    );

    // Running candidate residue; word 0 starts a fresh sum.
    always_comb begin
        res_sum = mod3_add((cnt == '0) ? 2'd0 : res_q, word_res);
    end

    assign reject_cnt = reject_q;
`endif

    // Main sequencer: IDLE -> COLLECT (NW words) -> HOLD until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            busy            <= 1'b0;
            cand.cand_valid <= 1'b0;
            cand.cand_out   <= '0;
`ifdef PRIME_CAND_MOD3_FILTER_EN
            res_q           <= '0;
            reject_q        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COLLECT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                COLLECT: begin
                    for (int unsigned k = 0; k < NW; k++) begin
                        if (cnt == CW'(k)) begin
                            cand.cand_out[k*WORD_WIDTH +: WORD_WIDTH] <= forced_word;
                        end
                    end
`ifdef PRIME_CAND_MOD3_FILTER_EN
                    res_q <= res_sum;
`endif
                    if (cnt == LAST) begin
`ifdef PRIME_CAND_MOD3_FILTER_EN
                        if (res_sum == 2'd0) begin
                            cnt <= '0;
                            if (reject_q != '1) reject_q <= reject_q + 16'd1;
                        end else begin
                            state           <= HOLD;
                            cand.cand_valid <= 1'b1;
                        end
`else
                        state           <= HOLD;
                        cand.cand_valid <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (cand.cand_ready) begin
                        cand.cand_valid <= 1'b0;
                        if (start) begin
                            state <= COLLECT;
                            cnt   <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    busy            <= 1'b0;
                    cand.cand_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_candidate_gen.sv
// Self-checking bench for prime_candidate_gen at KEY_WIDTH=64, WORD_WIDTH=32.
// Build with PRIME_CAND_MOD3_FILTER_EN defined to also exercise the filter.
module tb_prime_candidate_gen;

    localparam int unsigned WW = 32;
    localparam int unsigned KW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [WW-1:0] rand_in = '0;
    logic          busy;
`ifdef PRIME_CAND_MOD3_FILTER_EN
    logic [15:0]   reject_cnt;
`endif

    prime_candidate_gen_if #(.KEY_WIDTH(KW)) cand_if ();

    prime_candidate_gen #(.WORD_WIDTH(WW), .KEY_WIDTH(KW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rand_in (rand_in),
        .start   (start),
        .busy    (busy),
        .cand    (cand_if)
`ifdef PRIME_CAND_MOD3_FILTER_EN
        ,
        .reject_cnt (reject_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_rej = 0;

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request a candidate from IDLE.
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || cand_if.cand_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_accept: busy=%b valid=%b required busy=1 valid=0", busy, cand_if.cand_valid);
        end
    endtask

    // Drive words into COLLECT (from the queue first, then random) and
    // predict the presented candidate, including mod-3 discards.
    task automatic collect(input logic [31:0] ws[$], output logic [63:0] exp);
        int unsigned idx;
        logic [31:0] w0, w1;
        logic [63:0] c;
        bit done;
        idx = 0;
        done = 0;
        exp = '0;
        for (int attempt = 0; attempt < 64 && !done; attempt++) begin
            w0 = (idx < ws.size()) ? ws[idx] : $urandom; idx++;
            w1 = (idx < ws.size()) ? ws[idx] : $urandom; idx++;
            rand_in = w0;
            start = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (cand_if.cand_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL mid_collect: valid=%b busy=%b required valid=0 busy=1", cand_if.cand_valid, busy);
            end
            rand_in = w1;
            start = 1'($urandom_range(0, 1));
            step();
            start = 1'b0;
            c = {w1 | 32'hC000_0000, w0 | 32'h0000_0001};
`ifdef PRIME_CAND_MOD3_FILTER_EN
            if (c % 64'd3 == 64'd0) begin
                if (exp_rej < 65535) exp_rej++;
                checks++;
                if (cand_if.cand_valid !== 1'b0 || busy !== 1'b1 || reject_cnt !== 16'(exp_rej)) begin
                    errors++;
                    $display("FAIL discard: valid=%b busy=%b reject_cnt=%0d required valid=0 busy=1 reject_cnt=%0d",
                             cand_if.cand_valid, busy, reject_cnt, exp_rej);
                end
                continue;
            end
`endif
            done = 1;
            exp = c;
            checks++;
            if (cand_if.cand_valid !== 1'b1 || cand_if.cand_out !== c) begin
                errors++;
                $display("FAIL candidate: valid=%b cand_out=%h required valid=1 cand_out=%h",
                         cand_if.cand_valid, cand_if.cand_out, c);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout: no candidate presented within attempt budget");
        end
    endtask

    // Accept the held candidate, optionally requesting the next one.
    task automatic handshake(input bit s);
        cand_if.cand_ready = 1'b1;
        start = s;
        step();
        cand_if.cand_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (cand_if.cand_valid !== 1'b0 || busy !== s) begin
            errors++;
            $display("FAIL handshake: valid=%b busy=%b required valid=0 busy=%b", cand_if.cand_valid, busy, s);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        rst_n = 1'b1;
        exp_rej = 0;
        checks++;
        if (cand_if.cand_valid !== 1'b0 || busy !== 1'b0 || cand_if.cand_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b cand_out=%h required 0 0 0",
                     cand_if.cand_valid, busy, cand_if.cand_out);
        end
`ifdef PRIME_CAND_MOD3_FILTER_EN
        checks++;
        if (reject_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_reject: reject_cnt=%h required 0000", reject_cnt);
        end
`endif
    endtask

    task automatic test_zero_words();
        logic [31:0] ws[$];
        logic [63:0] e;
        ws = '{32'h0, 32'h0};
        pulse_start();
        collect(ws, e);
        checks++;
        if (cand_if.cand_out !== 64'hC000_0000_0000_0001) begin
            errors++;
            $display("FAIL zero_words: cand_out=%h required c000000000000001", cand_if.cand_out);
        end
        handshake(1'b0);
    endtask

    task automatic test_pattern();
        logic [31:0] ws[$];
        logic [63:0] e;
        ws = '{32'h1234_5678, 32'h0BCD_EF00};
        pulse_start();
        collect(ws, e);
`ifndef PRIME_CAND_MOD3_FILTER_EN
        checks++;
        if (cand_if.cand_out !== 64'hCBCD_EF00_1234_5679) begin
            errors++;
            $display("FAIL pattern: cand_out=%h required cbcdef0012345679", cand_if.cand_out);
        end
`endif
        handshake(1'b0);
    endtask

    task automatic test_hold_back_to_back();
        logic [31:0] ws[$];
        logic [63:0] e;
        ws.delete();
        pulse_start();
        collect(ws, e);
        for (int i = 0; i < 5; i++) begin
            rand_in = $urandom;
            cand_if.cand_ready = 1'b0;
            step();
            checks++;
            if (cand_if.cand_valid !== 1'b1 || busy !== 1'b1 || cand_if.cand_out !== e) begin
                errors++;
                $display("FAIL hold_stable: valid=%b busy=%b cand_out=%h required 1 1 %h",
                         cand_if.cand_valid, busy, cand_if.cand_out, e);
            end
        end
        handshake(1'b1);
        collect(ws, e);
        handshake(1'b0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] ws[$];
        logic [63:0] e;
        ws.delete();
        pulse_start();
        rand_in = $urandom;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_rej = 0;
        checks++;
        if (cand_if.cand_valid !== 1'b0 || busy !== 1'b0 || cand_if.cand_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b busy=%b cand_out=%h required 0 0 0",
                     cand_if.cand_valid, busy, cand_if.cand_out);
        end
        pulse_start();
        collect(ws, e);
        handshake(1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || cand_if.cand_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_candidate: busy=%b valid=%b required 0 0", busy, cand_if.cand_valid);
            end
        end
    endtask

`ifdef PRIME_CAND_MOD3_FILTER_EN
    task automatic test_filter();
        logic [31:0] ws[$];
        logic [63:0] e;
        ws = '{32'h2, 32'h0, 32'h0, 32'h0};
        pulse_start();
        collect(ws, e);
        checks++;
        if (reject_cnt !== 16'h1 || cand_if.cand_out !== 64'hC000_0000_0000_0001) begin
            errors++;
            $display("FAIL filter_discard: reject_cnt=%h cand_out=%h required 0001 c000000000000001",
                     reject_cnt, cand_if.cand_out);
        end
        handshake(1'b0);
        force dut.reject_q = 16'hFFFF;
        step();
        release dut.reject_q;
        exp_rej = 65535;
        pulse_start();
        collect(ws, e);
        checks++;
        if (reject_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL reject_saturate: reject_cnt=%h required ffff", reject_cnt);
        end
        handshake(1'b0);
    endtask
`endif

    task automatic test_random();
        logic [31:0] ws[$];
        logic [63:0] e;
        bit b2b;
        int unsigned waits;
        ws.delete();
        b2b = 0;
        for (int n = 0; n < 20; n++) begin
            if (!b2b) pulse_start();
            collect(ws, e);
            waits = $urandom_range(0, 3);
            for (int unsigned i = 0; i < waits; i++) begin
                rand_in = $urandom;
                step();
                checks++;
                if (cand_if.cand_valid !== 1'b1 || cand_if.cand_out !== e) begin
                    errors++;
                    $display("FAIL random_hold: valid=%b cand_out=%h required 1 %h",
                             cand_if.cand_valid, cand_if.cand_out, e);
                end
            end
            b2b = 1'($urandom_range(0, 1));
            if (n == 19) b2b = 0;
            handshake(b2b);
        end
`ifdef PRIME_CAND_MOD3_FILTER_EN
        checks++;
        if (reject_cnt !== 16'(exp_rej)) begin
            errors++;
            $display("FAIL random_reject: reject_cnt=%0d required %0d", reject_cnt, exp_rej);
        end
`endif
    endtask

    initial begin
        cand_if.cand_ready = 1'b0;
        test_reset();
        test_zero_words();
        test_pattern();
        test_hold_back_to_back();
        test_reset_mid();
`ifdef PRIME_CAND_MOD3_FILTER_EN
        test_filter();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time budget exhausted");
        $fatal(1);
    end

endmodule
